// File: rtl/universal_shift_reg.sv
// Parametrised universal shift register: shifts, rotates, arithmetic shift right,
// parallel load and clear, with a saturating count of shifts since the last load.
module universal_shift_reg #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic             sin,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] out,
  output logic             sout_r,
  output logic             sout_l,
  output logic [CW-1:0]    cnt,
  output logic             full
);

  localparam logic [2:0] MODE_HOLD = 3'b000;
  localparam logic [2:0] MODE_SHR  = 3'b001;
  localparam logic [2:0] MODE_SHL  = 3'b010;
  localparam logic [2:0] MODE_ROR  = 3'b011;
  localparam logic [2:0] MODE_ROL  = 3'b100;
  localparam logic [2:0] MODE_LOAD = 3'b101;
  localparam logic [2:0] MODE_ASR  = 3'b110;
  localparam logic [2:0] MODE_CLR  = 3'b111;

  localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH);

  logic [WIDTH-1:0] out_nxt;
  logic [CW-1:0]    cnt_nxt;
  logic             bump;

  // Next register contents and count for the selected operation
  always_comb begin
    out_nxt = out;
    cnt_nxt = cnt;
    bump    = 1'b0;
    if (en) begin
      case (mode)
        MODE_HOLD: begin
        end
        MODE_SHR: begin
          out_nxt = {sin, out[WIDTH-1:1]};
          bump    = 1'b1;
        end
        MODE_SHL: begin
          out_nxt = {out[WIDTH-2:0], sin};
          bump    = 1'b1;
        end
        MODE_ROR: begin
          out_nxt = {out[0], out[WIDTH-1:1]};
          bump    = 1'b1;
        end
        MODE_ROL: begin
          out_nxt = {out[WIDTH-2:0], out[WIDTH-1]};
          bump    = 1'b1;
        end
        MODE_LOAD: begin
          out_nxt = din;
          cnt_nxt = '0;
        end
        MODE_ASR: begin
          out_nxt = {out[WIDTH-1], out[WIDTH-1:1]};
          bump    = 1'b1;
        end
        MODE_CLR: begin
          out_nxt = '0;
          cnt_nxt = '0;
        end
        default: begin
        end
      endcase
      // Count saturates at WIDTH; the data operation still happens
      if (bump && (cnt != CNT_MAX)) begin
        cnt_nxt = cnt + CW'(1);
      end
    end
  end

  // full is registered alongside cnt so it tracks the count register exactly
  always_ff @(posedge clk) begin
    if (reset) begin
      out  <= '0;
      cnt  <= '0;
      full <= 1'b0;
    end else begin
      out  <= out_nxt;
      cnt  <= cnt_nxt;
      full <= (cnt_nxt == CNT_MAX);
    end
  end

  assign sout_r = out[0];
  assign sout_l = out[WIDTH-1];

endmodule

// File: tb/tb_universal_shift_reg.sv
// Bench for universal_shift_reg: three widths (4, 8, 2) driven in lockstep and
// compared each cycle against an arithmetic reference model, plus directed checks.
module tb_universal_shift_reg;

  logic       clk = 1'b0;
  logic       reset;
  logic       en;
  logic [2:0] mode;
  logic       sin;
  logic [7:0] din;

  logic [3:0] out4;
  logic       sr4, sl4, full4;
  logic [2:0] cnt4;
  logic [7:0] out8;
  logic       sr8, sl8, full8;
  logic [3:0] cnt8;
  logic [1:0] out2;
  logic       sr2, sl2, full2;
  logic [1:0] cnt2;

  int checks = 0;
  int errors = 0;

  localparam int unsigned WS[3] = '{4, 8, 2};
  int unsigned mv[3];
  int unsigned mc[3];

  always #5 clk = ~clk;

  universal_shift_reg #(.WIDTH(4)) u_w4 (
    .clk(clk), .reset(reset), .en(en), .mode(mode), .sin(sin), .din(din[3:0]),
    .out(out4), .sout_r(sr4), .sout_l(sl4), .cnt(cnt4), .full(full4));
  universal_shift_reg #(.WIDTH(8)) u_w8 (
    .clk(clk), .reset(reset), .en(en), .mode(mode), .sin(sin), .din(din),
    .out(out8), .sout_r(sr8), .sout_l(sl8), .cnt(cnt8), .full(full8));
  universal_shift_reg #(.WIDTH(2)) u_w2 (
    .clk(clk), .reset(reset), .en(en), .mode(mode), .sin(sin), .din(din[1:0]),
    .out(out2), .sout_r(sr2), .sout_l(sl2), .cnt(cnt2), .full(full2));

  task automatic cmp(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: register value as an integer, operations as shifts/masks on it
  function automatic void model(input int i, input logic r, input logic e,
                                input logic [2:0] m, input logic s, input logic [7:0] d);
    int unsigned w    = WS[i];
    int unsigned mask = (32'd1 << w) - 32'd1;
    int unsigned v    = mv[i];
    int unsigned c    = mc[i];
    int unsigned msb  = (v >> (w - 1)) & 32'd1;
    int unsigned lsb  = v & 32'd1;
    int unsigned sv   = 32'(s);
    if (r) begin
      v = 0; c = 0;
    end else if (e) begin
      case (m)
        3'd1: begin v = (v >> 1) | (sv << (w - 1));  c++; end
        3'd2: begin v = (v << 1) | sv;               c++; end
        3'd3: begin v = (v >> 1) | (lsb << (w - 1)); c++; end
        3'd4: begin v = (v << 1) | msb;              c++; end
        3'd5: begin v = 32'(d); c = 0; end
        3'd6: begin v = (v >> 1) | (msb << (w - 1)); c++; end
        3'd7: begin v = 0; c = 0; end
        default: ;
      endcase
      if (c > w) c = w;
    end
    mv[i] = v & mask;
    mc[i] = c;
  endfunction

  task automatic check_one(input string n, input int i, input logic [31:0] o,
                           input logic [31:0] c, input logic [31:0] f,
                           input logic [31:0] r, input logic [31:0] l);
    cmp({n, " out"}, o, mv[i]);
    cmp({n, " cnt"}, c, mc[i]);
    cmp({n, " full"}, f, 32'(mc[i] == WS[i]));
    cmp({n, " sout_r"}, r, mv[i] & 32'd1);
    cmp({n, " sout_l"}, l, (mv[i] >> (WS[i] - 1)) & 32'd1);
  endtask

  task automatic step(input logic r, input logic e, input logic [2:0] m,
                      input logic s, input logic [7:0] d);
    reset = r; en = e; mode = m; sin = s; din = d;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) model(i, r, e, m, s, d);
    check_one("w4", 0, 32'(out4), 32'(cnt4), 32'(full4), 32'(sr4), 32'(sl4));
    check_one("w8", 1, 32'(out8), 32'(cnt8), 32'(full8), 32'(sr8), 32'(sl8));
    check_one("w2", 2, 32'(out2), 32'(cnt2), 32'(full2), 32'(sr2), 32'(sl2));
  endtask

  initial begin
    logic [3:0] exp_sr[5];
    logic [3:0] exp_cnt[5];
    logic [3:0] exp_rol[4];
    logic [3:0] exp_asr[3];
    logic [3:0] bits;
    exp_sr  = '{4'h5, 4'h2, 4'h1, 4'h0, 4'h0};
    exp_cnt = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd4};
    exp_rol = '{4'h3, 4'h6, 4'hC, 4'h9};
    exp_asr = '{4'hC, 4'hE, 4'hF};
    bits    = 4'b1011;
    for (int i = 0; i < 3; i++) begin mv[i] = 0; mc[i] = 0; end

    // Reset dominates a pending load
    step(1, 1, 3'd5, 1'b0, 8'hFF);
    step(1, 1, 3'd5, 1'b0, 8'hFF);
    cmp("rst out", 32'(out4), 32'h0);
    cmp("rst cnt", 32'(cnt4), 32'h0);
    cmp("rst full", 32'(full4), 32'h0);
    step(0, 1, 3'd5, 1'b0, 8'hFF);
    cmp("rel load", 32'(out4), 32'hF);

    // Shift right from 1011 with sin=0
    step(0, 1, 3'd5, 1'b0, 8'h0B);
    for (int k = 0; k < 5; k++) begin
      cmp($sformatf("shr sout_r %0d", k), 32'(sr4), 32'(bits[0]));
      step(0, 1, 3'd1, 1'b0, 8'h00);
      cmp($sformatf("shr out %0d", k), 32'(out4), 32'(exp_sr[k]));
      cmp($sformatf("shr cnt %0d", k), 32'(cnt4), 32'(exp_cnt[k]));
      cmp($sformatf("shr full %0d", k), 32'(full4), 32'(k >= 3));
      bits = bits >> 1;
    end

    // Serial assembly: clear then shift left 1,0,1,1 (width sweep continues it)
    step(0, 1, 3'd7, 1'b0, 8'h00);
    step(0, 1, 3'd2, 1'b1, 8'h00);
    step(0, 1, 3'd2, 1'b0, 8'h00);
    cmp("w2 full at 2", 32'(full2), 32'h1);
    step(0, 1, 3'd2, 1'b1, 8'h00);
    step(0, 1, 3'd2, 1'b1, 8'h00);
    cmp("asm out", 32'(out4), 32'hB);
    cmp("asm full", 32'(full4), 32'h1);
    for (int k = 0; k < 5; k++) begin
      cmp($sformatf("w8 full pre %0d", k), 32'(full8), 32'(k == 4));
      step(0, 1, 3'd2, 1'(k), 8'h00);
    end
    cmp("w8 cnt sat", 32'(cnt8), 32'd8);
    cmp("w2 cnt sat", 32'(cnt2), 32'd2);
    step(0, 1, 3'd5, 1'b0, 8'h00);
    cmp("load cnt", 32'(cnt4), 32'h0);
    cmp("load full", 32'(full4), 32'h0);

    // Rotate left and arithmetic shift right
    step(0, 1, 3'd5, 1'b0, 8'h09);
    for (int k = 0; k < 4; k++) begin
      step(0, 1, 3'd4, 1'b0, 8'h00);
      cmp($sformatf("rol %0d", k), 32'(out4), 32'(exp_rol[k]));
    end
    step(0, 1, 3'd5, 1'b0, 8'h08);
    for (int k = 0; k < 3; k++) begin
      step(0, 1, 3'd6, 1'b1, 8'h00);
      cmp($sformatf("asr %0d", k), 32'(out4), 32'(exp_asr[k]));
    end
    step(0, 1, 3'd5, 1'b0, 8'h04);
    step(0, 1, 3'd6, 1'b1, 8'h00);
    cmp("asr pos", 32'(out4), 32'h2);

    // Enable low holds, then reset mid-sequence
    step(0, 1, 3'd5, 1'b0, 8'h0A);
    for (int k = 0; k < 3; k++) step(0, 0, 3'd1, 1'b1, 8'hFF);
    cmp("hold out", 32'(out4), 32'hA);
    cmp("hold cnt", 32'(cnt4), 32'h0);
    step(0, 1, 3'd1, 1'b0, 8'h00);
    step(0, 1, 3'd1, 1'b0, 8'h00);
    cmp("en cnt", 32'(cnt4), 32'h2);
    step(1, 1, 3'd1, 1'b1, 8'h00);
    cmp("mid rst out", 32'(out4), 32'h0);
    cmp("mid rst cnt", 32'(cnt4), 32'h0);

    // Randomised traffic against the model
    for (int k = 0; k < 400; k++) begin
      step(1'($urandom_range(0, 29) == 0), 1'($urandom_range(0, 4) != 0),
           3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 8'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
